// File: rtl/uart_recv.sv
// rtl/uart_recv.sv - 8N1 UART receiver: 3-flop line synchroniser, start validation,
// 2-of-3 mid-bit majority sampling, one-cycle done / framing-error strobes.
module uart_recv #(
    parameter int CLK_FREQUENCY = 10_000_000,
    parameter int UART_BPS      = 115200
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       uart_rxd,
    output logic [7:0] uart_dout,
    output logic       uart_done,
    output logic       uart_frame_err,
    output logic       uart_rx_busy
);

    localparam int BPS_CNT  = CLK_FREQUENCY / UART_BPS;
    localparam int HALF_CNT = BPS_CNT / 2;

    localparam logic [15:0] CNT_LAST = 16'(BPS_CNT - 1);
    localparam logic [15:0] SAMP_A   = 16'(HALF_CNT - 1);
    localparam logic [15:0] SAMP_B   = 16'(HALF_CNT);
    localparam logic [15:0] SAMP_C   = 16'(HALF_CNT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        rxd_d0_q, rxd_d0_d;
    logic        rxd_d1_q, rxd_d1_d;
    logic        rxd_d2_q, rxd_d2_d;
    logic [15:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [1:0]  samp_q, samp_d;
    logic [7:0]  dout_q, dout_d;
    logic        done_q, done_d;
    logic        ferr_q, ferr_d;

    logic start_flag;
    logic majority;
    logic decision;
    logic bit_wrap;

    assign start_flag = rxd_d2_q & ~rxd_d1_q;
    // The third vote is the live sample taken at the decision point itself.
    assign majority   = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxd_d1_q) | (samp_q[1] & rxd_d1_q);
    assign decision   = (clk_cnt_q == SAMP_C);
    assign bit_wrap   = (clk_cnt_q == CNT_LAST);

    always_comb begin
        rxd_d0_d  = uart_rxd;
        rxd_d1_d  = rxd_d0_q;
        rxd_d2_d  = rxd_d1_q;
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q + 16'd1;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        samp_d    = samp_q;
        dout_d    = dout_q;
        done_d    = 1'b0;
        ferr_d    = 1'b0;

        if (clk_cnt_q == SAMP_A) samp_d[0] = rxd_d1_q;
        if (clk_cnt_q == SAMP_B) samp_d[1] = rxd_d1_q;

        case (state_q)
            IDLE: begin
                clk_cnt_d = 16'd0;
                if (start_flag) state_d = START;
            end
            START: begin
                if (decision && majority) begin
                    state_d   = IDLE;
                    clk_cnt_d = 16'd0;
                end else if (bit_wrap) begin
                    state_d   = DATA;
                    clk_cnt_d = 16'd0;
                    bit_cnt_d = 3'd0;
                end
            end
            DATA: begin
                if (decision) shift_d[bit_cnt_q] = majority;
                if (bit_wrap) begin
                    clk_cnt_d = 16'd0;
                    if (bit_cnt_q == 3'd7) state_d = STOP;
                    else                   bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            STOP: begin
                // Leave at mid-stop so a following start edge is never missed.
                if (decision) begin
                    if (majority) begin
                        dout_d = shift_q;
                        done_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                    state_d   = IDLE;
                    clk_cnt_d = 16'd0;
                end
            end
            default: begin
                state_d   = IDLE;
                clk_cnt_d = 16'd0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            rxd_d0_q  <= 1'b1;
            rxd_d1_q  <= 1'b1;
            rxd_d2_q  <= 1'b1;
            clk_cnt_q <= 16'd0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            samp_q    <= 2'b11;
            dout_q    <= 8'h00;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rxd_d0_q  <= rxd_d0_d;
            rxd_d1_q  <= rxd_d1_d;
            rxd_d2_q  <= rxd_d2_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            samp_q    <= samp_d;
            dout_q    <= dout_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
        end
    end

    assign uart_dout      = dout_q;
    assign uart_done      = done_q;
    assign uart_frame_err = ferr_q;
    assign uart_rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_recv.sv
// tb/tb_uart_recv.sv - scoreboard bench for uart_recv: directed and randomized frames
`timescale 1ns/1ps
module tb_uart_recv;

    localparam int CLKF     = 10_000_000;
    localparam int BPS      = 115200;
    localparam int BPS_CNT  = CLKF / BPS;
    localparam int HALF_CNT = BPS_CNT / 2;
    localparam int LAT      = 9 * BPS_CNT + HALF_CNT + 4;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       uart_rxd = 1'b1;
    logic [7:0] uart_dout;
    logic       uart_done;
    logic       uart_frame_err;
    logic       uart_rx_busy;

    uart_recv #(.CLK_FREQUENCY(CLKF), .UART_BPS(BPS)) dut (
        .sys_clk        (sys_clk),
        .sys_rst_n      (sys_rst_n),
        .uart_rxd       (uart_rxd),
        .uart_dout      (uart_dout),
        .uart_done      (uart_done),
        .uart_frame_err (uart_frame_err),
        .uart_rx_busy   (uart_rx_busy)
    );

    always #50 sys_clk = ~sys_clk;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         done_cyc = -100000;
    logic [7:0] last_good = 8'h00;
    logic       prev_pulse = 1'b0;

    task automatic check(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            prev_pulse = 1'b0;
        end else begin
            if (uart_done || uart_frame_err) begin
                check(!(uart_done && uart_frame_err), "done_err_exclusive", {uart_done, uart_frame_err}, 0);
                check(!prev_pulse, "pulse_width", 2, 1);
                check(exp_q.size() != 0, "unexpected_pulse", {uart_done, uart_frame_err}, 0);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check(uart_frame_err == mon_e.err, "pulse_kind_err", uart_frame_err, mon_e.err);
                    check(uart_dout == mon_e.data, "dout", uart_dout, mon_e.data);
                end
                if (uart_done) done_cyc = cyc;
            end
            prev_pulse = uart_done | uart_frame_err;
        end
    end

    task automatic drive(input logic v, input int n);
        uart_rxd = v;
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic reset_mid(input int bc);
        sys_rst_n = 1'b0;
        #1;
        check(uart_dout == 8'h00, "midrst_dout", uart_dout, 0);
        check(uart_done == 1'b0, "midrst_done", uart_done, 0);
        check(uart_frame_err == 1'b0, "midrst_err", uart_frame_err, 0);
        check(uart_rx_busy == 1'b0, "midrst_busy", uart_rx_busy, 0);
        last_good = 8'h00;
        uart_rxd  = 1'b1;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        drive(1'b1, bc);
    endtask

    // Serial frame: start, 8 data LSB first, stop. Optional 1-clk spike inside a data bit,
    // optional reset partway through a data bit (frame then produces no expectation).
    task automatic send_frame(input logic [7:0] data, input bit stop_ok, input int bc,
                              input int spike_bit, input int spike_off, input int abort_bit);
        int   start_cyc;
        bit   aborted;
        exp_t e;
        aborted = 1'b0;
        if (abort_bit < 0) begin
            e.err  = !stop_ok;
            e.data = stop_ok ? data : last_good;
            exp_q.push_back(e);
            if (stop_ok) last_good = data;
        end
        start_cyc = cyc;
        drive(1'b0, bc);
        for (int i = 0; i < 8; i++) begin
            if (!aborted) begin
                if (i == abort_bit) begin
                    drive(data[i], bc / 2);
                    reset_mid(bc);
                    aborted = 1'b1;
                end else if (i == spike_bit) begin
                    drive(data[i], spike_off);
                    drive(~data[i], 1);
                    drive(data[i], bc - spike_off - 1);
                end else begin
                    drive(data[i], bc);
                end
            end
        end
        if (!aborted) begin
            drive(stop_ok, bc);
            if (!stop_ok) drive(1'b1, bc);
            if (stop_ok && bc == BPS_CNT)
                check((done_cyc - start_cyc) >= LAT - 1 && (done_cyc - start_cyc) <= LAT + 1,
                      "latency", done_cyc - start_cyc, LAT);
        end
    endtask

    task automatic false_start();
        bit seen_busy;
        seen_busy = 1'b0;
        uart_rxd  = 1'b0;
        for (int k = 0; k < HALF_CNT + 8; k++) begin
            if (k == 20) uart_rxd = 1'b1;
            @(negedge sys_clk);
            if (uart_rx_busy) seen_busy = 1'b1;
        end
        check(seen_busy, "false_start_busy_seen", seen_busy, 1);
        check(!uart_rx_busy, "false_start_busy_cleared", uart_rx_busy, 0);
        check(uart_dout == last_good, "false_start_dout", uart_dout, last_good);
    endtask

    initial begin
        int bc, gap, sb, so;
        logic [7:0] d;
        bit ok;

        repeat (3) @(negedge sys_clk);
        check(uart_dout == 8'h00, "reset_dout", uart_dout, 0);
        check(uart_done == 1'b0, "reset_done", uart_done, 0);
        check(uart_frame_err == 1'b0, "reset_err", uart_frame_err, 0);
        check(uart_rx_busy == 1'b0, "reset_busy", uart_rx_busy, 0);
        sys_rst_n = 1'b1;
        drive(1'b1, 2 * BPS_CNT);

        send_frame(8'hA5, 1'b1, BPS_CNT, -1, 0, -1);
        drive(1'b1, 20);

        send_frame(8'h00, 1'b1, BPS_CNT, -1, 0, -1);
        send_frame(8'hFF, 1'b1, BPS_CNT, -1, 0, -1);
        send_frame(8'h55, 1'b1, BPS_CNT, -1, 0, -1);
        drive(1'b1, BPS_CNT);

        false_start();
        drive(1'b1, BPS_CNT);

        send_frame(8'h3C, 1'b0, BPS_CNT, -1, 0, -1);
        send_frame(8'h81, 1'b1, BPS_CNT, -1, 0, -1);
        drive(1'b1, BPS_CNT);

        send_frame(8'h6B, 1'b1, BPS_CNT, 3, HALF_CNT + 1, -1);
        drive(1'b1, BPS_CNT);

        send_frame(8'h12, 1'b1, BPS_CNT, -1, 0, 4);
        send_frame(8'h7E, 1'b1, BPS_CNT, -1, 0, -1);
        drive(1'b1, BPS_CNT);
        send_frame(8'h7E, 1'b1, 83, -1, 0, -1);
        drive(1'b1, BPS_CNT);
        send_frame(8'h7E, 1'b1, 89, -1, 0, -1);
        drive(1'b1, BPS_CNT);

        for (int n = 0; n < 30; n++) begin
            d   = 8'($urandom);
            case ($urandom_range(0, 2))
                0:       bc = 83;
                1:       bc = 89;
                default: bc = BPS_CNT;
            endcase
            ok  = ($urandom_range(0, 4) != 0);
            sb  = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : -1;
            so  = int'($urandom_range(10, bc - 12));
            gap = ($urandom_range(0, 1) != 0) ? 0 : int'($urandom_range(1, 2 * bc));
            send_frame(d, ok, bc, sb, so, -1);
            drive(1'b1, gap);
        end

        for (int k = 0; k < 2000 && exp_q.size() != 0; k++) @(negedge sys_clk);
        check(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
        check(uart_dout == last_good, "final_dout", uart_dout, last_good);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
